// File: rtl/saturn_bus_prog_queue_pkg.sv
// -----------------------------------------------------------------------------
// saturn_bus_prog_queue_pkg
// Shared bus-command definitions for the Saturn bus program queue:
//   - BUSCMD_* nibble command codes driven onto the Saturn bus
//   - queue entry format {is_cmd, nibble} and helper to build an entry
//   - FSM state type used by the queue front end
// No ports (package).
// -----------------------------------------------------------------------------
package saturn_bus_prog_queue_pkg;

   // Entry format: bit 4 flags a command nibble, bits 3:0 carry the nibble.
   localparam int NIBBLE_W         = 4;
   localparam int ENTRY_W          = NIBBLE_W + 1;
   localparam int ENTRY_IS_CMD_BIT = NIBBLE_W;

   typedef logic [NIBBLE_W-1:0] nibble_t;
   typedef logic [ENTRY_W-1:0]  entry_t;

   // Saturn bus command codes.
   localparam nibble_t BUSCMD_PC_READ  = 4'h0;
   localparam nibble_t BUSCMD_DP_READ  = 4'h1;
   localparam nibble_t BUSCMD_DP_WRITE = 4'h2;
   localparam nibble_t BUSCMD_READ     = 4'h3;
   localparam nibble_t BUSCMD_LOAD_PC  = 4'h4;
   localparam nibble_t BUSCMD_LOAD_DP  = 4'h5;
   localparam nibble_t BUSCMD_CONFIG   = 4'h6;
   localparam nibble_t BUSCMD_UNCNFG   = 4'h7;
   localparam nibble_t BUSCMD_RESET    = 4'h8;
   localparam nibble_t BUSCMD_C_EQ_ID  = 4'hA;
   localparam nibble_t BUSCMD_SHUTDN   = 4'hB;

   typedef enum logic {
      IDLE = 1'b0,
      ADDR = 1'b1
   } prog_state_e;

   function automatic entry_t make_entry(input logic is_cmd, input nibble_t nib);
      return {is_cmd, nib};
   endfunction

endpackage

// File: rtl/saturn_bus_prog_mem.sv
// -----------------------------------------------------------------------------
// saturn_bus_prog_mem
// Entry storage for the bus program queue: one synchronous write port and two
// asynchronous read ports (head and peek).
// Ports:
//   i_clk      clock
//   i_we       write enable
//   i_waddr    write slot
//   i_wdata    entry to write
//   i_raddr_a  head read slot   -> o_rdata_a
//   i_raddr_b  peek read slot   -> o_rdata_b
// -----------------------------------------------------------------------------
module saturn_bus_prog_mem
   import saturn_bus_prog_queue_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  entry_t                   i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr_a,
   output entry_t                   o_rdata_a,
   input  logic [$clog2(DEPTH)-1:0] i_raddr_b,
   output entry_t                   o_rdata_b
);

   entry_t mem_q [DEPTH];

   // NOTE: storage carries no reset; validity is tracked by the pointers and
   // count, so clearing the array would only cost a reset fan-out.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = mem_q[i_raddr_a];
   assign o_rdata_b = mem_q[i_raddr_b];

endmodule

// File: rtl/saturn_bus_prog_queue.sv
// -----------------------------------------------------------------------------
// saturn_bus_prog_queue
// Circular queue of Saturn bus nibbles. A push stores a command nibble and,
// when requested, the following ADDR_NIBBLES address nibbles (LSB first, one
// per enabled cycle). The bus side pops entries from the head.
// Ports:
//   i_clk, i_reset_n (sync, active-low), i_clk_en (gates all non-reset updates)
//   i_push, i_cmd, i_with_addr, i_addr   push side
//   o_ready                              push will be accepted this cycle
//   i_pop, o_entry, o_valid              head entry {is_cmd, nibble}
//   o_count                              occupied entries
//   o_overflow                           sticky push-while-not-ready flag
// Optional build macro SATURN_BUSPROG_PEEK_EN adds i_dbg_idx / o_dbg_entry,
// a combinational read of slot (rd_ptr + i_dbg_idx) mod DEPTH.
// -----------------------------------------------------------------------------
module saturn_bus_prog_queue
   import saturn_bus_prog_queue_pkg::*;
#(
   parameter int DEPTH        = 32,
   parameter int ADDR_NIBBLES = 5
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   input  logic                        i_clk_en,
   input  logic                        i_push,
   input  logic [3:0]                  i_cmd,
   input  logic                        i_with_addr,
   input  logic [4*ADDR_NIBBLES-1:0]   i_addr,
   output logic                        o_ready,
   input  logic                        i_pop,
   output logic [4:0]                  o_entry,
   output logic                        o_valid,
   output logic [$clog2(DEPTH):0]      o_count,
   output logic                        o_overflow
`ifdef SATURN_BUSPROG_PEEK_EN
   ,
   input  logic [$clog2(DEPTH)-1:0]    i_dbg_idx,
   output logic [4:0]                  o_dbg_entry
`endif
);

   localparam int AW      = $clog2(DEPTH);
   localparam int CNT_W   = AW + 1;
   localparam int SEQ_LEN = 1 + ADDR_NIBBLES;
   localparam int NIB_W   = (ADDR_NIBBLES > 1) ? $clog2(ADDR_NIBBLES) : 1;
   localparam int ADDR_W  = NIBBLE_W * ADDR_NIBBLES;
   localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(ADDR_NIBBLES - 1);

   prog_state_e       state_q,   state_d;
   logic [AW-1:0]     wr_ptr_q,  wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q,  rd_ptr_d;
   logic [CNT_W-1:0]  count_q,   count_d;
   logic              ovf_q,     ovf_d;
   logic [NIB_W-1:0]  nib_idx_q, nib_idx_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;

   logic              en_ok;
   logic              push_fire;
   logic              pop_fire;
   logic              mem_we;
   entry_t            mem_wdata;
   entry_t            head_entry;
   logic [AW-1:0]     peek_addr;
   entry_t            peek_data;
   logic [CNT_W-1:0]  free_slots;

   // A reset cycle must never write storage, so it is folded into the enable.
   assign en_ok      = i_clk_en & i_reset_n;
   assign free_slots = CNT_W'(DEPTH) - count_q;

   // Ready demands room for a whole sequence even for command-only pushes,
   // so an address sequence can never stall on a full queue.
   assign o_ready    = (state_q == IDLE) && (free_slots >= CNT_W'(SEQ_LEN));
   assign push_fire  = en_ok & i_push & o_ready;
   assign o_valid    = (count_q != '0);
   assign pop_fire   = en_ok & i_pop & o_valid;

   // NOTE: every variable gets a default before the case, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      nib_idx_d = nib_idx_q;
      addr_d    = addr_q;
      ovf_d     = ovf_q;
      mem_we    = 1'b0;
      mem_wdata = make_entry(1'b1, i_cmd);

      case (state_q)
         IDLE: begin
            if (push_fire) begin
               mem_we    = 1'b1;
               addr_d    = i_addr;
               nib_idx_d = '0;
               if (i_with_addr) begin
                  state_d = ADDR;
               end
            end
         end
         ADDR: begin
            if (en_ok) begin
               // Address held in a shift register: low nibble is always next.
               mem_we    = 1'b1;
               mem_wdata = make_entry(1'b0, addr_q[NIBBLE_W-1:0]);
               addr_d    = addr_q >> NIBBLE_W;
               if (nib_idx_q == NIB_LAST) begin
                  state_d   = IDLE;
                  nib_idx_d = '0;
               end else begin
                  nib_idx_d = nib_idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (en_ok && i_push && !o_ready) begin
         ovf_d = 1'b1;
      end
      if (mem_we) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_fire) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(mem_we) - CNT_W'(pop_fire);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         nib_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         nib_idx_q <= nib_idx_d;
      end
   end

   // Address latch is only meaningful inside a sequence, so it has no reset.
   always_ff @(posedge i_clk) begin
      addr_q <= addr_d;
   end

`ifdef SATURN_BUSPROG_PEEK_EN
   assign peek_addr   = rd_ptr_q + i_dbg_idx;
   assign o_dbg_entry = peek_data;
`else
   entry_t peek_unused;
   assign peek_addr   = rd_ptr_q;
   assign peek_unused = peek_data;
`endif

   saturn_bus_prog_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .i_clk     (i_clk),
      .i_we      (mem_we),
      .i_waddr   (wr_ptr_q),
      .i_wdata   (mem_wdata),
      .i_raddr_a (rd_ptr_q),
      .o_rdata_a (head_entry),
      .i_raddr_b (peek_addr),
      .o_rdata_b (peek_data)
   );

   assign o_entry    = head_entry;
   assign o_count    = count_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_saturn_bus_prog_queue.sv
// -----------------------------------------------------------------------------
// tb_saturn_bus_prog_queue
// Self-checking bench for saturn_bus_prog_queue (default build, DEPTH=32,
// ADDR_NIBBLES=5). A queue-based model tracks stored entries and the pending
// address nibbles of an in-flight sequence; directed scenarios are followed
// by a randomized phase.
// -----------------------------------------------------------------------------
module tb_saturn_bus_prog_queue;
   import saturn_bus_prog_queue_pkg::*;

   localparam int DEPTH = 32;
   localparam int NIB   = 5;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_clk_en;
   logic        i_push;
   logic [3:0]  i_cmd;
   logic        i_with_addr;
   logic [19:0] i_addr;
   logic        o_ready;
   logic        i_pop;
   logic [4:0]  o_entry;
   logic        o_valid;
   logic [5:0]  o_count;
   logic        o_overflow;

   int total = 0;
   int bad   = 0;

   logic [4:0] mdl_q  [$];
   logic [4:0] pend_q [$];
   bit         mdl_ovf = 1'b0;

   logic [4:0] seq_exp [6] = '{5'h16, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01};

   always #5 i_clk = ~i_clk;

   saturn_bus_prog_queue #(
      .DEPTH        (DEPTH),
      .ADDR_NIBBLES (NIB)
   ) dut (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_clk_en    (i_clk_en),
      .i_push      (i_push),
      .i_cmd       (i_cmd),
      .i_with_addr (i_with_addr),
      .i_addr      (i_addr),
      .o_ready     (o_ready),
      .i_pop       (i_pop),
      .o_entry     (o_entry),
      .o_valid     (o_valid),
      .o_count     (o_count),
      .o_overflow  (o_overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, compare outputs with
   // the model, then apply the queue rules to the model at the rising edge.
   task automatic cycle(input bit rst_n, input bit en, input bit push, input bit wa,
                        input logic [3:0] cmd, input logic [19:0] addr, input bit pop);
      bit exp_ready;
      i_reset_n   = rst_n;
      i_clk_en    = en;
      i_push      = push;
      i_with_addr = wa;
      i_cmd       = cmd;
      i_addr      = addr;
      i_pop       = pop;
      #1;
      exp_ready = (pend_q.size() == 0) && ((DEPTH - mdl_q.size()) >= (1 + NIB));
      check("ready", o_ready, exp_ready);
      check("count", o_count, mdl_q.size());
      check("valid", o_valid, mdl_q.size() != 0);
      check("ovf",   o_overflow, mdl_ovf);
      check("cnt_max", o_count <= DEPTH, 1);
      if (mdl_q.size() != 0) check("head", o_entry, mdl_q[0]);
      @(posedge i_clk);
      if (!rst_n) begin
         mdl_q.delete();
         pend_q.delete();
         mdl_ovf = 1'b0;
      end else if (en) begin
         if (pop && mdl_q.size() != 0) void'(mdl_q.pop_front());
         if (pend_q.size() != 0) begin
            mdl_q.push_back(pend_q.pop_front());
         end else if (push && exp_ready) begin
            mdl_q.push_back({1'b1, cmd});
            if (wa) begin
               for (int k = 0; k < NIB; k++) pend_q.push_back({1'b0, addr[4*k +: 4]});
            end
         end
         if (push && !exp_ready) mdl_ovf = 1'b1;
      end
      @(negedge i_clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 4'h0, 20'h0, 0);
   endtask

   initial begin
      i_reset_n = 1'b0; i_clk_en = 1'b0; i_push = 1'b0; i_with_addr = 1'b0;
      i_cmd = 4'h0; i_addr = 20'h0; i_pop = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_count", o_count, 0);
      check("rst_valid", o_valid, 0);
      check("rst_ready", o_ready, 1);
      check("rst_ovf",   o_overflow, 0);

      // Command with address: 6 entries, ready low while the address streams.
      cycle(1, 1, 1, 1, BUSCMD_CONFIG, 20'h12345, 0);
      check("addr_busy", o_ready, 0);
      idle(5);
      check("seq_count", o_count, 6);
      for (int i = 0; i < 6; i++) begin
         check("seq_entry", o_entry, seq_exp[i]);
         cycle(1, 1, 0, 0, 4'h0, 20'h0, 1);
      end
      check("seq_empty", o_count, 0);

      // Clock enable toggling mid-sequence gives the same entries.
      cycle(1, 1, 1, 1, BUSCMD_CONFIG, 20'h12345, 0);
      cycle(1, 0, 0, 0, 4'h0, 20'h0, 0);
      check("en_hold", o_count, 1);
      for (int i = 0; i < 10; i++) cycle(1, i[0], 0, 0, 4'h0, 20'h0, 0);
      check("en_count", o_count, 6);
      for (int i = 0; i < 6; i++) begin
         check("en_entry", o_entry, seq_exp[i]);
         cycle(1, 1, 0, 0, 4'h0, 20'h0, 1);
      end

      // Wrap-around: offset the pointers, then fill to 30 entries.
      for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 4'(i), 20'h0, 0);
      for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 4'h0, 20'h0, 1);
      for (int s = 0; s < 5; s++) begin
         cycle(1, 1, 1, 1, 4'($urandom), 20'($urandom), 0);
         idle(5);
         check("fill_count", o_count, 6 * (s + 1));
      end
      check("full_ready", o_ready, 0);

      // Push while not ready: ignored and flagged.
      cycle(1, 1, 1, 1, BUSCMD_RESET, 20'hABCDE, 0);
      check("ovf_count", o_count, 30);
      check("ovf_set",   o_overflow, 1);
      for (int i = 0; i < 30; i++) cycle(1, 1, 0, 0, 4'h0, 20'h0, 1);
      check("ovf_sticky", o_overflow, 1);

      // Pop held throughout a sequence, then pop on empty.
      cycle(1, 1, 1, 1, BUSCMD_DP_WRITE, 20'h9F0A7, 1);
      for (int i = 0; i < 8; i++) begin
         check("pop_le1", o_count <= 1, 1);
         cycle(1, 1, 0, 0, 4'h0, 20'h0, 1);
      end
      check("pop_empty", o_count, 0);

      // Reset after the second address nibble, with clock enable low.
      cycle(1, 1, 1, 1, BUSCMD_LOAD_PC, 20'h54321, 0);
      idle(2);
      check("mid_count", o_count, 3);
      cycle(0, 0, 0, 0, 4'h0, 20'h0, 0);
      check("mr_count", o_count, 0);
      check("mr_valid", o_valid, 0);
      check("mr_ready", o_ready, 1);
      check("mr_ovf",   o_overflow, 0);
      idle(4);
      check("mr_abandon", o_count, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
               4'($urandom), 20'($urandom), ($urandom_range(0, 2) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/saturn_bus_prog_queue.md
SATURN_BUS_PROG_QUEUE -- requirements
Module: saturn_bus_prog_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 32, queue entries; power of two, 8..256.
REQ-002 SHALL have parameter ADDR_NIBBLES, default 5, address nibbles appended after an address-carrying command; range 1..8.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port i_clk_en, input, 1, clock enable; gates every non-reset update.
REQ-006 SHALL have port i_push, input, 1, command push request.
REQ-007 SHALL have port i_cmd, input, 4, bus command code.
REQ-008 SHALL have port i_with_addr, input, 1, append ADDR_NIBBLES address nibbles after the command.
REQ-009 SHALL have port i_addr, input, 4*ADDR_NIBBLES, address, nibble 0 in bits [3:0].
REQ-010 SHALL have port o_ready, output, 1, push accepted this cycle if asserted.
REQ-011 SHALL have port i_pop, input, 1, bus side consumes the head entry.
REQ-012 SHALL have port o_entry, output, 5, head entry {is_cmd, nibble}.
REQ-013 SHALL have port o_valid, output, 1, head entry present.
REQ-014 SHALL have port o_count, output, clog2(DEPTH)+1, occupied entries.
REQ-015 SHALL have port o_overflow, output, 1, sticky push-while-not-ready error.

Function
- REQ-016 SHALL store entries in a circular buffer with write and read pointers wrapping modulo DEPTH.
- REQ-017 SHALL use FSM states IDLE and ADDR.
  - IDLE to ADDR on an accepted push with i_with_addr=1.
  - ADDR to IDLE after the last nibble is written.
- REQ-018 SHALL assert o_ready only in IDLE with free space >= 1+ADDR_NIBBLES, independent of i_with_addr.
- REQ-019 SHALL, on an accepted push in a cycle with i_clk_en=1, write {1'b1,i_cmd} at the write pointer and latch i_addr internally.
- REQ-020 SHALL, in ADDR, write {1'b0, latched nibble k} for k=0..ADDR_NIBBLES-1, one per enabled cycle, LSB first.
- REQ-021 SHALL drive o_entry combinationally from the head slot and o_valid = (o_count != 0).
- REQ-022 SHALL make a written entry visible at o_valid/o_entry on the cycle after the write.
- REQ-023 SHALL, on i_pop with o_valid=1 and i_clk_en=1, advance the read pointer; i_pop while empty is ignored.
- REQ-024 SHALL compute o_count from writes minus pops in the same cycle, so simultaneous write and pop leaves the count unchanged.
- REQ-025 SHALL ignore i_push when o_ready=0, leave pointers and storage unchanged, and set o_overflow until reset.
- REQ-026 SHALL change no state when i_clk_en=0, except for reset.

Reset
- REQ-027 SHALL, when i_reset_n=0 at a rising edge, regardless of i_clk_en: FSM to IDLE, pointers 0, o_count 0, o_valid 0, o_overflow 0, nibble index 0.
- REQ-028 SHALL, when reset arrives mid-ADDR, abandon the partial sequence; no further nibbles are written.
- REQ-029 SHALL hold o_ready=1 on the first cycle after reset release; storage contents are not cleared.

Configuration
- REQ-030 SHALL, with SATURN_BUSPROG_PEEK_EN defined, add debug ports i_dbg_idx (clog2(DEPTH), offset from head) and o_dbg_entry (5), a combinational read of slot (rd_ptr+i_dbg_idx) mod DEPTH.
- REQ-031 SHALL, without SATURN_BUSPROG_PEEK_EN, have neither port and be otherwise identical.

Structure
- REQ-032 SHALL take command codes (BUSCMD_*) and the entry-format constants from the shared bus-command definitions file; no local redefinition.
- REQ-033 SHALL place storage in one sub-module, saturn_bus_prog_mem: synchronous write, asynchronous read, two read ports (head, peek).

Verification
- REQ-034 SHALL cover: push cmd 4'h6, with_addr=1, addr 20'h12345 -> over 6 enabled cycles entries 5'h16,5'h05,5'h04,5'h03,5'h02,5'h01; o_count=6; o_ready=0 during ADDR.
- REQ-035 SHALL cover: DEPTH=32, push 5 no-addr commands, pop 5, then push 6-entry sequences until o_count=30 -> wrap-around entries correct; o_ready=0 at count 27 and above; o_count never exceeds 32.
- REQ-036 SHALL cover: push while o_ready=0 -> storage and o_count unchanged; o_overflow=1 until i_reset_n=0.
- REQ-037 SHALL cover: pop held high throughout an address sequence -> o_count stays 0 or 1; entries consumed in order; pop on empty has no effect.
- REQ-038 SHALL cover: i_reset_n=0 after the 2nd address nibble -> next cycle o_count=0, o_valid=0, IDLE, o_ready=1.
- REQ-039 SHALL cover: i_clk_en toggling 1-0-1 during ADDR -> nibbles written only on enabled cycles; sequence identical to REQ-034.
